// File: rtl/sprite_linebuf_pkg.sv
// sprite_pkg: shared constants and types for the sprite line buffer.
//   LINE_W          pixel slots per bank (power of two)
//   ACTIVE_W        first x position whose writes are discarded
//   COLOR_W         colour index width (palette bank + pen)
//   x_t / color_t   x-address and colour-index types
//   TRANSPARENT_PEN pen value that never marks a pixel as present
package sprite_pkg;

    localparam int LINE_W   = 512;
    localparam int ACTIVE_W = 384;
    localparam int COLOR_W  = 8;
    localparam int X_W      = $clog2(LINE_W);

    typedef logic [X_W-1:0]     x_t;
    typedef logic [COLOR_W-1:0] color_t;

    localparam logic [3:0] TRANSPARENT_PEN = 4'h0;

    // One extra bit so ACTIVE_W == LINE_W is still representable.
    localparam logic [X_W:0] ACTIVE_LIM = (X_W+1)'(ACTIVE_W);

    function automatic logic in_active(input x_t x);
        return {1'b0, x} < ACTIVE_LIM;
    endfunction

    function automatic logic pen_opaque(input color_t c);
        return c[3:0] != TRANSPARENT_PEN;
    endfunction

endpackage

// File: rtl/sprite_linebuf_bank.sv
// spr_line_bank: one bank of the sprite line buffer.
// Holds the colour RAM (no reset) and the occupancy bitmap (async reset).
// Write port applies the discard rules; read port returns colour and
// occupancy one dclk after rd_en and clears the location on that edge.
// Optional macro SPRITE_LAST_WINS_EN: later opaque writes overwrite.
//   dclk, reset_n       clock, async active-low reset
//   wr_en/wr_x/wr_color write request
//   rd_en/rd_x          read-and-clear request
//   rd_color/rd_occ     registered read result
module spr_line_bank
    import sprite_pkg::*;
(
    input  logic   dclk,
    input  logic   reset_n,
    input  logic   wr_en,
    input  x_t     wr_x,
    input  color_t wr_color,
    input  logic   rd_en,
    input  x_t     rd_x,
    output color_t rd_color,
    output logic   rd_occ
);

    color_t            mem_q [LINE_W];
    logic [LINE_W-1:0] occ_q, occ_d;
    color_t            rd_color_q, rd_color_d;
    logic              rd_occ_q, rd_occ_d;
    logic              wr_ok;

    always_comb begin
        wr_ok = wr_en && pen_opaque(wr_color) && in_active(wr_x);
`ifndef SPRITE_LAST_WINS_EN
        // First opaque write of the line owns the pixel.
        wr_ok = wr_ok && !occ_q[wr_x];
`endif
    end

    // Read and write never target the same bank in one cycle, so the
    // clear and set below cannot collide.
    always_comb begin
        occ_d      = occ_q;
        rd_color_d = rd_color_q;
        rd_occ_d   = rd_occ_q;
        if (rd_en) begin
            rd_color_d      = mem_q[rd_x];
            rd_occ_d        = occ_q[rd_x];
            occ_d[rd_x]     = 1'b0;
        end
        if (wr_ok) begin
            occ_d[wr_x] = 1'b1;
        end
    end

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q    <= '0;
            rd_occ_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            rd_occ_q <= rd_occ_d;
        end
    end

    // Colour storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge dclk) begin
        if (wr_ok) begin
            mem_q[wr_x] <= wr_color;
        end
        rd_color_q <= rd_color_d;
    end

    assign rd_color = rd_color_q;
    assign rd_occ   = rd_occ_q;

endmodule

// File: rtl/sprite_linebuf.sv
// sprite_linebuf: double-buffered sprite line buffer feeding the palette.
// The renderer writes bank wr_bank while the other bank is read out in
// pixel order and cleared behind the read. Banks swap on line_start.
// Optional macro SPRITE_LAST_WINS_EN (see spr_line_bank).
//   dclk, reset_n         pixel clock, async active-low reset
//   ce_pix, rd_x          one read per enabled cycle
//   line_start            swaps banks
//   wr_en, wr_x, wr_color renderer pixel write
//   cb, spr_opaque        read result, 2 dclk after the read
//   wr_bank               bank currently written
module sprite_linebuf
    import sprite_pkg::*;
(
    input  logic   dclk,
    input  logic   reset_n,
    input  logic   ce_pix,
    input  logic   line_start,
    input  logic   wr_en,
    input  x_t     wr_x,
    input  color_t wr_color,
    input  x_t     rd_x,
    output color_t cb,
    output logic   spr_opaque,
    output logic   wr_bank
);

    logic   wr_bank_q, wr_bank_d;
    logic   rd_vld_q, rd_vld_d;
    logic   rd_bank_q, rd_bank_d;
    color_t cb_q, cb_d;
    logic   opq_q, opq_d;
    color_t bank_color [2];
    logic   bank_occ   [2];
    color_t sel_color;
    logic   sel_occ;

    // All accesses in the swap cycle use wr_bank_q, the pre-toggle bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        spr_line_bank u_bank (
            .dclk     (dclk),
            .reset_n  (reset_n),
            .wr_en    (wr_en && (wr_bank_q == 1'(b))),
            .wr_x     (wr_x),
            .wr_color (wr_color),
            .rd_en    (ce_pix && (wr_bank_q != 1'(b))),
            .rd_x     (rd_x),
            .rd_color (bank_color[b]),
            .rd_occ   (bank_occ[b])
        );
    end

    always_comb begin
        wr_bank_d = wr_bank_q ^ line_start;
        rd_vld_d  = ce_pix;
        // Remember which bank the in-flight read went to, so a swap
        // between read and output stage does not redirect it.
        rd_bank_d = ce_pix ? ~wr_bank_q : rd_bank_q;

        sel_color = bank_color[rd_bank_q];
        sel_occ   = bank_occ[rd_bank_q];
        cb_d      = cb_q;
        opq_d     = opq_q;
        if (rd_vld_q) begin
            opq_d = sel_occ;
            cb_d  = sel_occ ? sel_color : '0;
        end
    end

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_bank_q <= 1'b0;
            cb_q      <= '0;
            opq_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_vld_q  <= rd_vld_d;
            rd_bank_q <= rd_bank_d;
            cb_q      <= cb_d;
            opq_q     <= opq_d;
        end
    end

    assign cb         = cb_q;
    assign spr_opaque = opq_q;
    assign wr_bank    = wr_bank_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Bench for sprite_linebuf: directed scenarios plus random traffic, all
// checked against a per-bank array model with a queue of scheduled results.
module tb_sprite_linebuf;

    localparam int ACT   = 384;
    localparam int SLOTS = 512;
`ifdef SPRITE_LAST_WINS_EN
    localparam bit LAST_WINS = 1'b1;
`else
    localparam bit LAST_WINS = 1'b0;
`endif

    logic       dclk = 1'b0;
    logic       reset_n;
    logic       ce_pix;
    logic       line_start;
    logic       wr_en;
    logic [8:0] wr_x;
    logic [7:0] wr_color;
    logic [8:0] rd_x;
    logic [7:0] cb;
    logic       spr_opaque;
    logic       wr_bank;

    sprite_linebuf dut (
        .dclk       (dclk),
        .reset_n    (reset_n),
        .ce_pix     (ce_pix),
        .line_start (line_start),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_color   (wr_color),
        .rd_x       (rd_x),
        .cb         (cb),
        .spr_opaque (spr_opaque),
        .wr_bank    (wr_bank)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        int         due;
        logic [7:0] cb;
        logic       op;
    } res_t;

    bit         m_occ [2][SLOTS];
    logic [7:0] m_col [2][SLOTS];
    bit         m_wb;
    res_t       pend [$];
    logic [7:0] exp_cb;
    logic       exp_op;
    int         edge_n;
    int         checks;
    int         failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int x = 0; x < SLOTS; x++) m_occ[b][x] = 1'b0;
        m_wb   = 1'b0;
        pend.delete();
        exp_cb = 8'h00;
        exp_op = 1'b0;
    endtask

    // One dclk: apply inputs, advance the model, check all outputs.
    task automatic step(input int ls, input int we, input int wx, input int wc,
                        input int ce, input int rx);
        int   rb;
        res_t r;
        line_start = (ls != 0);
        wr_en      = (we != 0);
        wr_x       = 9'(wx);
        wr_color   = 8'(wc);
        ce_pix     = (ce != 0);
        rd_x       = 9'(rx);
        if (ce != 0) begin
            rb    = m_wb ? 0 : 1;
            r.due = edge_n + 2;
            r.op  = m_occ[rb][rx];
            r.cb  = m_occ[rb][rx] ? m_col[rb][rx] : 8'h00;
            pend.push_back(r);
            m_occ[rb][rx] = 1'b0;
        end
        if (we != 0 && wx < ACT && (wc & 'hF) != 0 && (LAST_WINS || !m_occ[m_wb][wx])) begin
            m_occ[m_wb][wx] = 1'b1;
            m_col[m_wb][wx] = 8'(wc);
        end
        if (ls != 0) m_wb = ~m_wb;
        @(posedge dclk);
        edge_n++;
        #1;
        while (pend.size() > 0 && pend[0].due <= edge_n) begin
            r      = pend.pop_front();
            exp_cb = r.cb;
            exp_op = r.op;
        end
        chk("cb", 32'(cb), 32'(exp_cb));
        chk("spr_opaque", 32'(spr_opaque), 32'(exp_op));
        chk("wr_bank", 32'(wr_bank), 32'(m_wb));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0; failures = 0; edge_n = 0;
        reset_n = 1'b0; ce_pix = 1'b0; line_start = 1'b0; wr_en = 1'b0;
        wr_x = '0; wr_color = '0; rd_x = '0;
        model_reset();
        repeat (3) @(posedge dclk);
        #1 reset_n = 1'b1;
        chk("rst_cb", 32'(cb), 32'h00);
        chk("rst_opaque", 32'(spr_opaque), 32'h0);
        chk("rst_wr_bank", 32'(wr_bank), 32'h0);

        // Empty buffer after reset reads as transparent everywhere.
        step(1, 0, 0, 0, 0, 0);
        for (int x = 0; x < ACT; x++) step(0, 0, 0, 0, 1, x);
        idle(); idle();

        // Basic write / swap / read, then clear-on-read.
        step(0, 1, 10, 'h35, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 10);
        idle();
        chk("basic_cb", 32'(cb), 32'h35);
        chk("basic_opaque", 32'(spr_opaque), 32'h1);
        step(0, 0, 0, 0, 1, 10);
        idle();
        chk("cleared_opaque", 32'(spr_opaque), 32'h0);
        chk("cleared_cb", 32'(cb), 32'h00);

        // Write priority on the same x.
        step(0, 1, 20, 'h41, 0, 0);
        step(0, 1, 20, 'h72, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 20);
        idle();
        chk("priority_cb", 32'(cb), LAST_WINS ? 32'h72 : 32'h41);

        // Transparent pen and out-of-active writes are dropped.
        step(0, 1, 5, 'h30, 0, 0);
        step(0, 1, 400, 'h11, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5);
        idle();
        chk("pen0_opaque", 32'(spr_opaque), 32'h0);
        step(0, 0, 0, 0, 1, 400);
        idle();
        chk("x400_opaque", 32'(spr_opaque), 32'h0);

        // Ping-pong across two lines.
        chk("pp_bank0", 32'(wr_bank), 32'h0);
        step(0, 1, 7, 'h19, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("pp_bank1", 32'(wr_bank), 32'h1);
        step(0, 1, 7, 'h2A, 1, 7);
        idle();
        chk("pp_lineA_cb", 32'(cb), 32'h19);
        step(1, 0, 0, 0, 0, 0);
        chk("pp_bank2", 32'(wr_bank), 32'h0);
        step(0, 0, 0, 0, 1, 7);
        idle();
        chk("pp_lineB_cb", 32'(cb), 32'h2A);

        // Swap, write and read in one cycle: the write lands pre-swap.
        step(1, 1, 3, 'h55, 1, 3);
        step(0, 0, 0, 0, 1, 3);
        idle();
        chk("simul_cb", 32'(cb), 32'h55);
        chk("simul_opaque", 32'(spr_opaque), 32'h1);

        // Partial line then asynchronous reset mid-cycle.
        for (int x = 50; x < 60; x++) step(0, 1, x, 'h60 + x, 0, 0);
        step(0, 1, 61, 'h07, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_cb", 32'(cb), 32'h00);
        chk("midrst_opaque", 32'(spr_opaque), 32'h0);
        chk("midrst_wr_bank", 32'(wr_bank), 32'h0);
        model_reset();
        @(posedge dclk); @(posedge dclk);
        #1 reset_n = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        for (int x = 0; x < SLOTS; x++) step(0, 0, 0, 0, 1, x);
        step(1, 0, 0, 0, 0, 0);
        for (int x = 0; x < SLOTS; x++) step(0, 0, 0, 0, 1, x);
        idle(); idle();

        // Random traffic, biased toward a small x window for collisions.
        for (int i = 0; i < 3000; i++) begin
            int wx, rx;
            wx = $urandom_range(0, 1) ? $urandom_range(0, 31) : $urandom_range(0, SLOTS - 1);
            rx = $urandom_range(0, 1) ? $urandom_range(0, 31) : $urandom_range(0, SLOTS - 1);
            step(($urandom_range(0, 99) < 3) ? 1 : 0,
                 $urandom_range(0, 1), wx, $urandom_range(0, 255),
                 $urandom_range(0, 1), rx);
        end
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
